// File: rtl/cpu_pkg.sv
// Shared constants for the memory-mapped interrupt controller: register offsets,
// TCTRL bit positions, default window base and the ID priority encoder.
package cpu_pkg;

  localparam logic [15:0] INT_BASE_DEFAULT = 16'hFF00;

  localparam logic [2:0] INT_OFS_PEND    = 3'd0;
  localparam logic [2:0] INT_OFS_MASK    = 3'd1;
  localparam logic [2:0] INT_OFS_ID      = 3'd2;
  localparam logic [2:0] INT_OFS_TRELOAD = 3'd3;
  localparam logic [2:0] INT_OFS_TCTRL   = 3'd4;
  localparam logic [2:0] INT_OFS_TCOUNT  = 3'd5;

  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_AUTO = 1;

  // Lowest set bit wins, so source 0 (the timer) has the highest priority.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/int_timer.sv
// Prescaled down-counting timer; o_fire pulses on the tick that finds TCOUNT at zero.
module int_timer
  import cpu_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ce,
  input  logic        i_wr_reload,
  input  logic        i_wr_ctrl,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_reload,
  output logic [15:0] o_count,
  output logic        o_en,
  output logic        o_auto,
  output logic        o_fire
);

  localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

  logic [15:0] presc;
  logic        tick;

  assign tick   = i_ce && o_en && (presc == PS_MAX);
  assign o_fire = tick && (o_count == 16'd0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc    <= '0;
      o_count  <= '0;
      o_reload <= '0;
      o_en     <= 1'b0;
      o_auto   <= 1'b0;
    end else if (i_ce) begin
      if (o_en) presc <= tick ? 16'd0 : presc + 16'd1;
      if (tick) begin
        if (o_count != 16'd0) o_count <= o_count - 16'd1;
        else if (o_auto)      o_count <= o_reload;
        else                  o_en    <= 1'b0;
      end
      // Bus writes come last so they override the internal EN clear and count update.
      if (i_wr_ctrl) begin
        o_en   <= i_wdata[TCTRL_EN];
        o_auto <= i_wdata[TCTRL_AUTO];
      end
      if (i_wr_reload) begin
        o_reload <= i_wdata;
        o_count  <= i_wdata;
        presc    <= '0;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: bus decode, source synchronisers, PEND/MASK, ID encode
// and registered read mux around the int_timer block.
module int_ctrl
  import cpu_pkg::*;
#(
  parameter logic [15:0] BASE     = INT_BASE_DEFAULT,
  parameter int          PRESCALE = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ce,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  input  logic        i_we,
  output logic [15:0] o_rdata,
  output logic        o_sel,
  input  logic [7:1]  i_irq,
  output logic        o_int
);

  logic [7:0]  pend, mask, pend_n, mask_n, masked, pend_clr;
  logic [7:1]  irq_s1, irq_s2, irq_d;
  logic [15:0] treload, tcount, rd_mux, id_val;
  logic [2:0]  ofs;
  logic        hit, wr, t_en, t_auto, t_fire;

  assign hit = (i_addr[15:3] == BASE[15:3]);
  assign ofs = i_addr[2:0];
  assign wr  = i_ce && i_we && hit;

  int_timer #(.PRESCALE(PRESCALE)) u_timer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_ce        (i_ce),
    .i_wr_reload (wr && (ofs == INT_OFS_TRELOAD)),
    .i_wr_ctrl   (wr && (ofs == INT_OFS_TCTRL)),
    .i_wdata     (i_wdata),
    .o_reload    (treload),
    .o_count     (tcount),
    .o_en        (t_en),
    .o_auto      (t_auto),
    .o_fire      (t_fire)
  );

  assign masked = pend & mask;
  assign id_val = {|masked, 12'b0, lowest_set(masked)};

  // A new event in the same cycle as its W1C clear keeps the bit set.
  assign pend_clr = (wr && (ofs == INT_OFS_PEND)) ? i_wdata[7:0] : 8'h00;
  assign pend_n   = (pend & ~pend_clr) | {irq_s2 & ~irq_d, t_fire};
  assign mask_n   = (wr && (ofs == INT_OFS_MASK)) ? i_wdata[7:0] : mask;

  always_comb begin
    rd_mux = 16'h0000;
    case (ofs)
      INT_OFS_PEND:    rd_mux = {8'h00, pend};
      INT_OFS_MASK:    rd_mux = {8'h00, mask};
      INT_OFS_ID:      rd_mux = id_val;
      INT_OFS_TRELOAD: rd_mux = treload;
      INT_OFS_TCTRL:   rd_mux = {14'b0, t_auto, t_en};
      INT_OFS_TCOUNT:  rd_mux = tcount;
      default:         rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      irq_s1  <= '0;
      irq_s2  <= '0;
      irq_d   <= '0;
      pend    <= '0;
      mask    <= '0;
      o_int   <= 1'b0;
      o_sel   <= 1'b0;
      o_rdata <= '0;
    end else if (i_ce) begin
      irq_s1  <= i_irq;
      irq_s2  <= irq_s1;
      irq_d   <= irq_s2;
      pend    <= pend_n;
      mask    <= mask_n;
      o_int   <= |(pend_n & mask_n);
      o_sel   <= hit;
      o_rdata <= hit ? rd_mux : 16'h0000;
    end
  end

endmodule
